// File: rtl/terminate_unit_if.sv
// Issue-side and result-side handshake bundle for terminate_unit.
interface terminate_unit_if #(
  parameter int ADDR_W = 16,
  parameter int FLAG_W = 8
);
  logic              flush;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] reg_base_val;
  logic [FLAG_W-1:0] flag_vals;
  logic [7:0]        offset;
  logic [3:0]        immediate;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] result_addr;
  logic              result_valid;
  logic              result_ready;
  logic              term_failed;
  logic [7:0]        fail_count;

  // Issue logic / consumer side.
  modport master (
    output flush, opcode, reg_base_val, flag_vals, offset, immediate,
           instr_valid, result_ready,
    input  instr_ready, result_addr, result_valid, term_failed, fail_count
  );

  // Resolution unit side.
  modport slave (
    input  flush, opcode, reg_base_val, flag_vals, offset, immediate,
           instr_valid, result_ready,
    output instr_ready, result_addr, result_valid, term_failed, fail_count
  );
endinterface

// File: rtl/terminate_unit.sv
// Buffered branch/terminate resolution unit: a small FIFO of micro-ops whose
// head is evaluated each cycle; taken entries emit a target address on a
// registered valid/ready port, not-taken entries pulse term_failed.
module terminate_unit #(
  parameter int ADDR_W = 16,
  parameter int FLAG_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  terminate_unit_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = $clog2(FLAG_W);

  typedef struct packed {
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base;
    logic [FLAG_W-1:0] flags;
    logic [7:0]        offset;
    logic [3:0]        imm;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            wr_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              push;
  logic              resolve;
  logic [ADDR_W-1:0] addend;
  logic              head_taken;
  logic [ADDR_W-1:0] head_target;

  logic              result_valid_r;
  logic [ADDR_W-1:0] result_addr_r;
  logic              term_failed_r;
  logic [7:0]        fail_count_r;

  // Upper opcode bits carry no meaning for this unit.
  logic              unused_opcode;
  assign unused_opcode = ^bus.opcode[3:2];

  // Ready never looks at a same-cycle pop, so a full FIFO always refuses.
  assign bus.instr_ready = (count < (PTR_W+1)'(DEPTH)) & ~bus.flush;
  assign push            = bus.instr_valid & bus.instr_ready;
  assign resolve         = (count != '0) & (~result_valid_r | bus.result_ready) & ~bus.flush;

  assign bus.result_valid = result_valid_r;
  assign bus.result_addr  = result_addr_r;
  assign bus.term_failed  = term_failed_r;
  assign bus.fail_count   = fail_count_r;

  // Pack the incoming micro-op into a FIFO entry.
  always_comb begin
    wr_entry.mode   = bus.opcode[1:0];
    wr_entry.base   = bus.reg_base_val;
    wr_entry.flags  = bus.flag_vals;
    wr_entry.offset = bus.offset;
    wr_entry.imm    = bus.immediate;
  end

  // Evaluate the head entry: addend select, flag condition and target.
  always_comb begin
    head = mem[rd_ptr];
    unique case (head.mode)
      2'b00:   addend = {{(ADDR_W-8){1'b0}}, head.offset};
      2'b01:   addend = {{(ADDR_W-4){1'b0}}, head.imm};
      default: addend = {{(ADDR_W-8){head.offset[7]}}, head.offset};
    endcase
    // Odd modes are unconditional; even modes test one flag against the
    // inverted polarity bit.
    head_taken  = head.mode[0] | (head.flags[head.imm[IDX_W-1:0]] == ~head.imm[3]);
    head_target = head.base + addend;
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; only pointers and count need one,
  // since an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (resolve) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, resolve})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output slot, failure pulse and saturating failure counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid_r <= 1'b0;
      result_addr_r  <= '0;
      term_failed_r  <= 1'b0;
      fail_count_r   <= '0;
    end else if (bus.flush) begin
      // A result offered in the flush cycle is discarded, never delivered.
      result_valid_r <= 1'b0;
      term_failed_r  <= 1'b0;
    end else if (resolve) begin
      if (head_taken) begin
        result_valid_r <= 1'b1;
        result_addr_r  <= head_target;
        term_failed_r  <= 1'b0;
      end else begin
        result_valid_r <= 1'b0;
        term_failed_r  <= 1'b1;
        if (fail_count_r != 8'hFF) fail_count_r <= fail_count_r + 1'b1;
      end
    end else begin
      term_failed_r <= 1'b0;
      if (bus.result_ready) result_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_terminate_unit.sv
// Self-checking bench for terminate_unit: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_terminate_unit;
  localparam int ADDR_W = 16;
  localparam int FLAG_W = 8;
  localparam int DEPTH  = 4;
  localparam int AMOD   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  terminate_unit_if #(.ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) bus ();

  terminate_unit #(.ADDR_W(ADDR_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int mode;
    int base;
    int flags;
    int off;
    int imm;
  } op_t;

  op_t q[$];
  bit  m_rv = 1'b0;
  bit  m_tf = 1'b0;
  int  m_ra = 0;
  int  m_fc = 0;

  function automatic bit op_taken(input op_t e);
    int k;
    int pol;
    if (e.mode == 1 || e.mode == 3) return 1'b1;
    k   = e.imm % FLAG_W;
    pol = (e.imm >> 3) & 1;
    return ((e.flags >> k) & 1) == (1 - pol);
  endfunction

  function automatic int op_target(input op_t e);
    int add;
    case (e.mode)
      0:       add = e.off;
      1:       add = e.imm;
      default: add = (e.off >= 128) ? e.off - 256 : e.off;
    endcase
    return (e.base + add + AMOD) % AMOD;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit  do_push;
    bit  do_res;
    op_t n;
    op_t h;
    if (rst) begin
      q.delete();
      m_rv = 1'b0;
      m_tf = 1'b0;
      m_ra = 0;
      m_fc = 0;
    end else begin
      n.mode  = int'(bus.opcode[1:0]);
      n.base  = int'(bus.reg_base_val);
      n.flags = int'(bus.flag_vals);
      n.off   = int'(bus.offset);
      n.imm   = int'(bus.immediate);
      do_push = bus.instr_valid && (q.size() < DEPTH) && !bus.flush;
      do_res  = (q.size() > 0) && (!m_rv || bus.result_ready) && !bus.flush;
      if (bus.flush) begin
        q.delete();
        m_rv = 1'b0;
        m_tf = 1'b0;
      end else if (do_res) begin
        h = q.pop_front();
        if (op_taken(h)) begin
          m_rv = 1'b1;
          m_ra = op_target(h);
          m_tf = 1'b0;
        end else begin
          m_rv = 1'b0;
          m_tf = 1'b1;
          if (m_fc < 255) m_fc++;
        end
      end else begin
        m_tf = 1'b0;
        if (bus.result_ready) m_rv = 1'b0;
      end
      if (do_push) q.push_back(n);
    end
  end

  // Per-cycle comparison, mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("result_valid", int'(bus.result_valid), int'(m_rv));
      check("result_addr",  int'(bus.result_addr),  m_ra);
      check("term_failed",  int'(bus.term_failed),  int'(m_tf));
      check("fail_count",   int'(bus.fail_count),   m_fc);
      check("instr_ready",  int'(bus.instr_ready),
            int'((q.size() < DEPTH) && !bus.flush));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int mode, input int base, input int flags,
                       input int off, input int imm);
    bus.opcode       = 4'(mode);
    bus.reg_base_val = ADDR_W'(base);
    bus.flag_vals    = FLAG_W'(flags);
    bus.offset       = 8'(off);
    bus.immediate    = 4'(imm);
    bus.instr_valid  = 1'b1;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.result_ready = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.opcode       = '0;
    bus.reg_base_val = '0;
    bus.flag_vals    = '0;
    bus.offset       = '0;
    bus.immediate    = '0;
    #12 rst = 1'b0;
    tick(1);

    // Reset state.
    check("rst_valid", int'(bus.result_valid), 0);
    check("rst_addr",  int'(bus.result_addr),  0);
    check("rst_tf",    int'(bus.term_failed),  0);
    check("rst_fc",    int'(bus.fail_count),   0);
    check("rst_ready", int'(bus.instr_ready),  1);

    // Mode 01: two edges from presentation to result.
    bus.result_ready = 1'b1;
    drive(1, 'h1000, 0, 0, 'h5);
    tick(1); idle();
    check("m01_latency", int'(bus.result_valid), 0);
    tick(1);
    check("m01_valid", int'(bus.result_valid), 1);
    check("m01_addr",  int'(bus.result_addr),  'h1005);
    check("m01_tf",    int'(bus.term_failed),  0);
    tick(1);

    // Mode 10 taken with negative offset, then not-taken via polarity.
    drive(2, 'h0010, 'h04, 'hF0, 'h2);
    tick(1); idle(); tick(1);
    check("m10_valid", int'(bus.result_valid), 1);
    check("m10_addr",  int'(bus.result_addr),  'h0000);
    drive(2, 'h0010, 'h04, 'hF0, 'hA);
    tick(1); idle(); tick(1);
    check("m10_nt_tf",    int'(bus.term_failed),  1);
    check("m10_nt_valid", int'(bus.result_valid), 0);
    check("m10_nt_fc",    int'(bus.fail_count),   1);
    tick(1);
    check("m10_nt_pulse", int'(bus.term_failed), 0);

    // Address wrap and sign extension in mode 11.
    drive(0, 'hFFFF, 'h01, 'h02, 'h0);
    tick(1); idle(); tick(1);
    check("m00_wrap", int'(bus.result_addr), 'h0001);
    drive(3, 'h0000, 0, 'h80, 0);
    tick(1); idle(); tick(1);
    check("m11_sext", int'(bus.result_addr), 'hFF80);
    tick(1);

    // Back-pressure: five pushes fill output slot plus FIFO.
    bus.result_ready = 1'b0;
    drive(1, 'h0100, 0,    0,    1); tick(1);
    drive(1, 'h0200, 0,    0,    2); tick(1);
    drive(0, 'h0300, 0,    0,    0); tick(1);
    drive(3, 'h0400, 0,    'h7F, 0); tick(1);
    drive(2, 'h0500, 'hFF, 0,    8); tick(1);
    idle();
    check("bp_valid", int'(bus.result_valid), 1);
    check("bp_addr",  int'(bus.result_addr),  'h0101);
    check("bp_full",  int'(bus.instr_ready),  0);
    tick(1);
    check("bp_hold", int'(bus.result_addr), 'h0101);
    // Release; a sixth push offered while full must wait one cycle.
    bus.result_ready = 1'b1;
    drive(0, 'h0500, 'h80, 'h10, 7);
    tick(1);
    check("dr1_addr", int'(bus.result_addr), 'h0202);
    tick(1); idle();
    check("dr2_tf",    int'(bus.term_failed),  1);
    check("dr2_valid", int'(bus.result_valid), 0);
    check("dr2_fc",    int'(bus.fail_count),   2);
    tick(1);
    check("dr3_addr", int'(bus.result_addr), 'h047F);
    tick(1);
    check("dr4_tf", int'(bus.term_failed), 1);
    tick(1);
    check("dr5_valid", int'(bus.result_valid), 1);
    check("dr5_addr",  int'(bus.result_addr),  'h0510);
    tick(1);
    check("dr6_empty", int'(bus.result_valid), 0);

    // Flush with a valid output and three buffered entries.
    bus.result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 'h0A00, 0, 0, i);
      tick(1);
    end
    idle();
    check("fl_pre_valid", int'(bus.result_valid), 1);
    bus.flush        = 1'b1;
    bus.result_ready = 1'b1;
    #1;
    check("fl_ready_low", int'(bus.instr_ready), 0);
    tick(1);
    bus.flush = 1'b0;
    #1;
    check("fl_valid", int'(bus.result_valid), 0);
    check("fl_ready", int'(bus.instr_ready),  1);
    check("fl_fc",    int'(bus.fail_count),   3);
    tick(3);
    check("fl_no_more", int'(bus.result_valid), 0);

    // Saturation of the failure counter.
    bus.result_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(260);
    idle();
    tick(2);
    check("sat_fc", int'(bus.fail_count), 255);

    // Asynchronous reset in the middle of buffered traffic.
    bus.result_ready = 1'b0;
    drive(1, 'h0C00, 0, 0, 3);
    tick(3);
    check("mid_valid", int'(bus.result_valid), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", int'(bus.result_valid), 0);
    check("arst_addr",  int'(bus.result_addr),  0);
    check("arst_tf",    int'(bus.term_failed),  0);
    check("arst_fc",    int'(bus.fail_count),   0);
    check("arst_ready", int'(bus.instr_ready),  1);
    idle();
    #2 rst = 1'b0;
    tick(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, AMOD - 1)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)));
      bus.instr_valid  = ($urandom_range(0, 3) != 0);
      bus.result_ready = ($urandom_range(0, 3) != 0);
      bus.flush        = ($urandom_range(0, 31) == 0);
      tick(1);
    end
    bus.flush        = 1'b0;
    bus.result_ready = 1'b1;
    idle();
    tick(8);
    check("end_empty", int'(bus.result_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/terminate_unit.md
# terminate_unit

Buffered, parametrised branch/terminate resolution unit for the out-of-order core. It accepts terminate/branch micro-ops from issue into an internal FIFO and evaluates the head entry's flag condition. Taken entries produce a target address on a registered valid/ready output. Not-taken entries produce a one-cycle `term_failed` pulse and a saturating failure count. Compared with the combinational terminate pipeline it adds buffering, a signed-offset mode, width parameters, flush and statistics.

## Interface
- `ADDR_W`, default 16: address width.
- `FLAG_W`, default 8: flag vector width; legal values 2, 4, 8.
- `DEPTH`, default 4: input FIFO entries; power of 2, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous squash of all buffered and output state.
- `opcode`  in  4  micro-op mode; bits [3:2] ignored.
- `reg_base_val`  in  ADDR_W  base address.
- `flag_vals`  in  FLAG_W  flag snapshot.
- `offset`  in  8  branch offset.
- `immediate`  in  4  condition select / small addend.
- `instr_valid`  in  1  input handshake.
- `instr_ready`  out  1  input handshake.
- `result_addr`  out  ADDR_W  target address (registered).
- `result_valid`  out  1  output handshake (registered).
- `result_ready`  in  1  output handshake.
- `term_failed`  out  1  registered one-cycle pulse per not-taken entry.
- `fail_count`  out  8  saturating count of `term_failed` pulses.

## Operation
- The FIFO stores `{opcode[1:0], reg_base_val, flag_vals, offset, immediate}` per entry.
- Push when `instr_valid & instr_ready`.
- `instr_ready = (count < DEPTH) & ~flush`. It is combinational and does not depend on a same-cycle pop.
- Mode, `opcode[1:0]`:
  - 00: conditional; addend = zero-extended `offset`.
  - 01: unconditional; addend = zero-extended `immediate`.
  - 10: conditional; addend = sign-extended `offset`.
  - 11: unconditional; addend = sign-extended `offset`.
- Condition (conditional modes only):
  - Index `k = immediate[$clog2(FLAG_W)-1:0]`; `immediate[3]` is the polarity bit.
  - Taken iff `flag_vals[k] == ~immediate[3]`.
  - Unconditional modes are always taken.
- Target = `reg_base_val + addend`, computed modulo 2^ADDR_W. Carry is discarded.
- Resolve condition: FIFO non-empty and output slot free or draining (`~result_valid | result_ready`) and `~flush`. On resolve the head is popped and:
  - Taken: the output register loads the target and `result_valid` = 1.
  - Not taken: the output register is not loaded (`result_valid` goes 0 if it was draining), `term_failed` = 1 for exactly the next cycle, and `fail_count` increments, saturating at 255.
- Output holds `result_addr` stable while `result_valid & ~result_ready`.
- Flush (sync), at the edge where `flush` = 1:
  - FIFO emptied; `result_valid` cleared; `term_failed` cleared.
  - No resolve occurs; an in-flight push is dropped.
  - `fail_count` is unaffected.
  - If `flush` and `result_ready` are high together, the output is discarded, not delivered.
- Only `rst` clears `fail_count`.

## Timing
- Reset values: FIFO empty, `instr_ready` = 1 (when `flush` = 0), `result_valid` = 0, `result_addr` = 0, `term_failed` = 0, `fail_count` = 0.
- Latency: an entry accepted at edge N is resolved at edge N+1 at the earliest.
  - `result_valid` or `term_failed` is visible in cycle N+1 (after that edge).
  - Minimum latency is 2 edges from presentation to output.
- Throughput: one resolve per cycle with `result_ready` held high. A full FIFO with a continuous drain sustains one push per cycle after the first pop frees a slot.
- Full (`count == DEPTH`): `instr_ready` = 0 and the push is refused. A same-cycle pop does not enable the push.
- Empty: no resolve. Output state and `term_failed` deassert per the rules above.
- Simultaneous push and pop: both occur and count is unchanged. FIFO pointers wrap modulo DEPTH.
- Back-pressure: with `result_valid & ~result_ready` the head stalls, including not-taken heads. Ordering of `term_failed` against results is therefore preserved.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Buffered entries are lost.

## Test plan
- Mode 01, base 0x1000, imm 0x5, `result_ready` = 1 -> `result_addr` 0x1005 and `result_valid` = 1 exactly 2 edges after the push; `term_failed` stays 0.
- Mode 10, base 0x0010, offset 0xF0, flags 0x04, imm 0x2 (bit 2, want 1) -> target 0x0000 (sign-extended −16). Same with imm 0xA -> `term_failed` pulses one cycle, no result, `fail_count` = 1.
- Mode 00, base 0xFFFF, offset 0x02 -> `result_addr` 0x0001 (wrap). Mode 11, base 0x0000, offset 0x80 -> 0xFF80.
- `result_ready` = 0 and push 5 entries with DEPTH = 4 -> first resolves to output, next 4 fill the FIFO, then `instr_ready` = 0. Release `result_ready` -> results drain one per cycle in push order, with not-taken entries pulsing `term_failed` in order.
- Flush with 3 buffered entries and a valid output, `result_ready` = 1 same cycle -> next cycle `result_valid` = 0, FIFO empty, no further results, `fail_count` unchanged.
- Push 260 not-taken entries -> `fail_count` saturates at 255. Assert `rst` mid-stream -> all outputs read reset values immediately.
